// File: rtl/sampler_if.sv
// Readout bus of the capture buffer: window address, read data, release and done flag.
// The reader drives the master side; the sampler is the slave.
interface sampler_if #(
    parameter int unsigned Width     = 8,
    parameter int unsigned DepthLog2 = 10
) ();
    logic [DepthLog2-1:0] rd_addr;
    logic [Width-1:0]     rd_data;
    logic                 rd_release;
    logic                 done;

    modport master (
        output rd_addr,
        output rd_release,
        input  rd_data,
        input  done
    );

    modport slave (
        input  rd_addr,
        input  rd_release,
        output rd_data,
        output done
    );
endinterface

// File: rtl/sampler.sv
// Capture controller: records samples into a circular buffer, holds the trigger block in reset
// until the pre-trigger history is filled, then freezes a DEPTH-sample window for readout.
module sampler #(
    parameter int unsigned Width     = 8,
    parameter int unsigned DepthLog2 = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 arm_i,
    input  logic [DepthLog2-1:0] pre_samples_i,
    input  logic [Width-1:0]     data_i,
    input  logic                 data_valid_i,
    input  logic                 trigger_i,
    input  logic                 force_i,
    output logic                 trig_rst_o,
    output logic                 busy_o,
    output logic [2:0]           state_o,
    sampler_if.slave             rd_if
);
    localparam int unsigned Depth = 2 ** DepthLog2;

    typedef logic [DepthLog2-1:0] ptr_t;
    typedef logic [DepthLog2:0]   cnt_t;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPreFill = 3'd1,
        StArmed   = 3'd2,
        StPost    = 3'd3,
        StDone    = 3'd4
    } state_e;

    logic [Width-1:0] mem_q [Depth];

    state_e           state_q;
    ptr_t             wr_ptr_q, fill_q, pre_q, trig_addr_q, start_addr_q;
    cnt_t             post_q;
    logic             trig_pending_q, trig_rst_q, busy_q, done_q;
    logic [Width-1:0] rd_data_q;

    logic arm_ok, trig_evt, wr_en, fill_done, trig_smp, counting, last_wr;
    cnt_t post_cnt;
    ptr_t trig_ptr;

    always_comb begin
        arm_ok   = arm_i && (state_q == StIdle || state_q == StDone);
        trig_evt = (state_q == StArmed) && (trigger_i || force_i);
        case (state_q)
            StPreFill:       wr_en = data_valid_i && (fill_q != pre_q);
            StArmed, StPost: wr_en = data_valid_i;
            default:         wr_en = 1'b0;
        endcase
        // Leave PRE_FILL right after the last history write so no sample is skipped.
        fill_done = (fill_q == pre_q) || (wr_en && (ptr_t'(fill_q + ptr_t'(1)) == pre_q));
        counting  = trig_evt || (state_q == StPost);
        post_cnt  = (state_q == StArmed) ? cnt_t'(Depth) - cnt_t'(pre_q) : post_q;
        trig_smp  = wr_en && (trig_evt || (state_q == StPost && trig_pending_q));
        trig_ptr  = trig_smp ? wr_ptr_q : trig_addr_q;
        last_wr   = counting && wr_en && (post_cnt == cnt_t'(1));
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            trig_rst_q     <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            rd_data_q      <= '0;
            wr_ptr_q       <= '0;
            fill_q         <= '0;
            pre_q          <= '0;
            post_q         <= '0;
            trig_pending_q <= 1'b0;
            trig_addr_q    <= '0;
            start_addr_q   <= '0;
        end else begin
            rd_data_q <= '0;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (arm_ok) begin
                state_q        <= StPreFill;
                pre_q          <= pre_samples_i;
                wr_ptr_q       <= '0;
                fill_q         <= '0;
                trig_pending_q <= 1'b0;
                busy_q         <= 1'b1;
                done_q         <= 1'b0;
                trig_rst_q     <= 1'b1;
            end else begin
                case (state_q)
                    StPreFill: begin
                        if (wr_en) begin
                            fill_q <= fill_q + ptr_t'(1);
                        end
                        if (fill_done) begin
                            state_q    <= StArmed;
                            trig_rst_q <= 1'b0;
                        end
                    end
                    StArmed, StPost: begin
                        if (counting) begin
                            post_q <= wr_en ? post_cnt - cnt_t'(1) : post_cnt;
                        end
                        if (trig_evt) begin
                            state_q        <= StPost;
                            trig_pending_q <= !trig_smp;
                        end
                        if (trig_smp) begin
                            trig_addr_q    <= wr_ptr_q;
                            trig_pending_q <= 1'b0;
                        end
                        if (last_wr) begin
                            state_q      <= StDone;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            trig_rst_q   <= 1'b1;
                            start_addr_q <= trig_ptr - pre_q;
                        end
                    end
                    StDone: begin
                        if (rd_if.rd_release) begin
                            state_q <= StIdle;
                            done_q  <= 1'b0;
                        end else begin
                            rd_data_q <= mem_q[ptr_t'(start_addr_q + rd_if.rd_addr)];
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign trig_rst_o    = trig_rst_q;
    assign busy_o        = busy_q;
    assign state_o       = state_q;
    assign rd_if.rd_data = rd_data_q;
    assign rd_if.done    = done_q;
endmodule

// File: tb/tb_sampler.sv
// Randomized bench for sampler: a queue of every valid sample offered after arm is the reference;
// the expected window is cut from it around the trigger sample.
module tb_sampler;
    localparam int unsigned W  = 8;
    localparam int unsigned DL = 4;
    localparam int          D  = 16;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b0;
    logic          arm         = 1'b0;
    logic [DL-1:0] pre_samples = '0;
    logic [W-1:0]  data        = '0;
    logic          data_valid  = 1'b0;
    logic          trigger     = 1'b0;
    logic          force_in    = 1'b0;
    logic          trig_rst, busy;
    logic [2:0]    state;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] hist[$];
    logic [W-1:0] win[D];

    sampler_if #(.Width(W), .DepthLog2(DL)) rd_if ();

    sampler #(.Width(W), .DepthLog2(DL)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .arm_i        (arm),
        .pre_samples_i(pre_samples),
        .data_i       (data),
        .data_valid_i (data_valid),
        .trigger_i    (trigger),
        .force_i      (force_in),
        .trig_rst_o   (trig_rst),
        .busy_o       (busy),
        .state_o      (state),
        .rd_if        (rd_if.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // vmode: 0 always valid, 1 valid on even cycles, 2 random. abort_post < 0 disables the abort.
    task automatic run_capture(input int pre, input int trig_at, input bit use_force,
                               input int vmode, input bit rnd_data, input bit rel_with_arm,
                               input bit noisy, input int abort_post);
        int c, nvb, tidx, post_cyc, exp_st;
        bit evt, fin, fire, armed, v, aborted;
        logic [W-1:0] d;
        hist.delete();
        arm              = 1'b1;
        pre_samples      = DL'(pre);
        rd_if.rd_release = rel_with_arm;
        data_valid       = 1'($urandom_range(0, 1));
        data             = W'($urandom);
        tick();
        arm              = 1'b0;
        rd_if.rd_release = 1'b0;
        c = 0; nvb = 0; tidx = -1; post_cyc = 0;
        evt = 1'b0; fin = 1'b0; aborted = 1'b0;
        while (!fin && !aborted && c < 400) begin
            armed  = (c >= 1) && (nvb >= pre);
            exp_st = !armed ? 1 : (evt ? 3 : 2);
            n_cmp++;
            if (state !== 3'(exp_st)) begin
                n_err++;
                $display("FAIL cap_state c=%0d: got %0d expected %0d", c, state, exp_st);
            end
            n_cmp++;
            if (trig_rst !== (exp_st == 1)) begin
                n_err++;
                $display("FAIL cap_trig_rst c=%0d: got %b expected %b", c, trig_rst, exp_st == 1);
            end
            n_cmp++;
            if (busy !== 1'b1 || rd_if.done !== 1'b0) begin
                n_err++;
                $display("FAIL cap_busy_done c=%0d: got %b/%b expected 1/0", c, busy, rd_if.done);
            end
            if (exp_st == 3 && post_cyc == abort_post) begin
                #2 rst_n = 1'b0;
                #1;
                n_cmp++;
                if (state !== 3'd0 || trig_rst !== 1'b1 || rd_if.done !== 1'b0 || busy !== 1'b0
                    || rd_if.rd_data !== '0) begin
                    n_err++;
                    $display("FAIL abort_reset: got st=%0d tr=%b dn=%b bz=%b rd=%0h expected 0/1/0/0/0",
                             state, trig_rst, rd_if.done, busy, rd_if.rd_data);
                end
                force_in = 1'b0; trigger = 1'b0; data_valid = 1'b0; arm = 1'b0;
                tick();
                rst_n   = 1'b1;
                aborted = 1'b1;
            end else begin
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = (c % 2 == 0);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                d          = rnd_data ? W'($urandom) : W'(c);
                data_valid = v;
                data       = d;
                fire       = armed && !evt && (c >= trig_at);
                force_in   = use_force && fire;
                if (!use_force && fire) trigger = 1'b1;
                if (noisy) begin
                    arm         = 1'($urandom_range(0, 1));
                    pre_samples = DL'($urandom);
                end
                if (fire) evt = 1'b1;
                if (v) begin
                    hist.push_back(d);
                    nvb++;
                    if (evt && tidx < 0) tidx = hist.size() - 1;
                end
                if (exp_st == 3) post_cyc++;
                if (tidx >= 0 && hist.size() == tidx + D - pre) fin = 1'b1;
                tick();
                c++;
            end
        end
        force_in = 1'b0; trigger = 1'b0; arm = 1'b0; data_valid = 1'b0;
        if (!aborted) begin
            n_cmp++;
            if (!fin) begin
                n_err++;
                $display("FAIL cap_timeout: got no window after %0d cycles expected done", c);
            end
            n_cmp++;
            if (state !== 3'd4 || rd_if.done !== 1'b1 || busy !== 1'b0 || trig_rst !== 1'b1) begin
                n_err++;
                $display("FAIL cap_done: got st=%0d dn=%b bz=%b tr=%b expected 4/1/0/1",
                         state, rd_if.done, busy, trig_rst);
            end
            if (fin) begin
                for (int i = 0; i < D; i++) win[i] = hist[tidx - pre + i];
            end
        end
    endtask

    task automatic read_window(input bit do_release);
        int off, a;
        off = $urandom_range(0, D - 1);
        for (int i = 0; i < D; i++) begin
            a             = (i * 5 + off) % D;
            rd_if.rd_addr = DL'(a);
            data_valid    = 1'($urandom_range(0, 1));
            data          = W'($urandom);
            tick();
            n_cmp++;
            if (rd_if.rd_data !== win[a]) begin
                n_err++;
                $display("FAIL window[%0d]: got %0h expected %0h", a, rd_if.rd_data, win[a]);
            end
        end
        data_valid = 1'b0;
        if (do_release) begin
            rd_if.rd_release = 1'b1;
            tick();
            rd_if.rd_release = 1'b0;
            n_cmp++;
            if (state !== 3'd0 || rd_if.done !== 1'b0 || rd_if.rd_data !== '0) begin
                n_err++;
                $display("FAIL release: got st=%0d dn=%b rd=%0h expected 0/0/0",
                         state, rd_if.done, rd_if.rd_data);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (state !== 3'd0 || trig_rst !== 1'b1 || busy !== 1'b0 || rd_if.done !== 1'b0
            || rd_if.rd_data !== '0) begin
            n_err++;
            $display("FAIL reset: got st=%0d tr=%b bz=%b dn=%b rd=%0h expected 0/1/0/0/0",
                     state, trig_rst, busy, rd_if.done, rd_if.rd_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_force_window();
        run_capture(4, 20, 1'b1, 0, 1'b0, 1'b0, 1'b0, -1);
        read_window(1'b1);
    endtask

    task automatic test_pre_zero();
        run_capture(0, 5, 1'b0, 0, 1'b0, 1'b0, 1'b0, -1);
        read_window(1'b1);
    endtask

    task automatic test_pre_max();
        run_capture(15, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, -1);
        read_window(1'b1);
    endtask

    task automatic test_valid_gaps();
        run_capture(3, 11, 1'b0, 1, 1'b0, 1'b0, 1'b0, -1);
        read_window(1'b1);
        run_capture(7, 9, 1'b1, 2, 1'b1, 1'b0, 1'b1, -1);
        read_window(1'b1);
    endtask

    task automatic test_reset_abort();
        run_capture(2, 6, 1'b1, 0, 1'b1, 1'b0, 1'b0, 3);
        run_capture(5, 12, 1'b0, 2, 1'b1, 1'b0, 1'b0, -1);
        read_window(1'b1);
    endtask

    task automatic test_back_to_back();
        run_capture(6, 10, 1'b1, 0, 1'b1, 1'b0, 1'b1, -1);
        read_window(1'b0);
        run_capture(9, 14, 1'b0, 2, 1'b1, 1'b1, 1'b1, -1);
        read_window(1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_capture($urandom_range(0, D - 1), $urandom_range(0, 40), 1'($urandom_range(0, 1)),
                        2, 1'b1, 1'b0, 1'b1, -1);
            read_window(1'b1);
        end
    endtask

    initial begin
        rd_if.rd_addr    = '0;
        rd_if.rd_release = 1'b0;
        test_reset();
        test_force_window();
        test_pre_zero();
        test_pre_max();
        test_valid_gaps();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of run expected summary");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sampler.md
# sampler

Capture controller that consumes the `trigger` pulse from the edge-trigger block and owns its `trig_rst` input. It records the ADC stream into an internal circular buffer, holds the trigger block in reset until the pre-trigger history is filled, and freezes a window of `pre_samples` samples before the trigger point plus the remaining samples after it. It then exposes the frozen window for readout and re-arms on request.

## Interface
- `WIDTH`, 8: sample width; matches the trigger block `WIDTH`.
- `DEPTH_LOG2`, 10: buffer depth is `DEPTH = 2**DEPTH_LOG2` samples.
- `clk` in 1: single system clock; all logic runs on its rising edge.
- `rst` in 1: asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- `arm` in 1: start a capture; sampled in IDLE and DONE.
- `pre_samples` in DEPTH_LOG2: pre-trigger sample count; latched when `arm` is accepted.
- `data` in WIDTH: ADC sample.
- `data_valid` in 1: `data` is written when high.
- `trigger` in 1: trigger flag from the trigger block; level, sticky until `trig_rst`.
- `force` in 1: manual trigger; honoured in ARMED only.
- `trig_rst` out 1: holds the trigger block cleared; registered.
- `busy` out 1: high in PRE_FILL, ARMED and POST.
- `done` out 1: the capture window is frozen and readable.
- `state` out 3: IDLE=0, PRE_FILL=1, ARMED=2, POST=3, DONE=4.
- `rd_addr` in DEPTH_LOG2: logical index into the window; 0 is the oldest sample.
- `rd_data` out WIDTH: buffer word; 1-cycle latency.
- `rd_release` in 1: ends readout and returns the block to IDLE.

## Operation
- Reset values:
  - `state` = IDLE
  - `trig_rst` = 1
  - `busy` = 0
  - `done` = 0
  - `rd_data` = 0
  - write pointer = 0
  - all counters = 0
- Buffer contents are not reset.
- **IDLE**
  - `trig_rst` = 1.
  - When `arm` is high: latch `pre_samples` into `pre_q`, clear the write pointer and fill counter, go to PRE_FILL.
- **PRE_FILL**
  - `trig_rst` = 1.
  - Each `data_valid` writes `data` at the write pointer, increments the pointer (mod `DEPTH`) and increments the fill counter.
  - When fill counter == `pre_q`, go to ARMED. With `pre_q` = 0 this happens on the first PRE_FILL cycle.
  - `trigger` and `force` are ignored.
- **ARMED**
  - `trig_rst` = 0.
  - Writes continue and wrap, overwriting the oldest history.
  - A trigger event is `trigger | force` seen high in ARMED.
  - On a trigger event: load the post counter with `DEPTH - pre_q`, set `trig_pending`, go to POST.
- **POST**
  - `trig_rst` = 0.
  - The trigger sample is the first sample written on or after the cycle of the trigger event. If `data_valid` is high in the event cycle itself, that sample is the trigger sample and counts toward post.
  - On the trigger sample: record `trig_addr` = its physical address.
  - Each write decrements the post counter.
  - The write that brings the counter to 0 is the last write. Then: `start_addr = trig_addr - pre_q` (mod `DEPTH`), go to DONE.
- **DONE**
  - `trig_rst` = 1, `done` = 1, no writes.
  - `rd_data` returns `buf[(start_addr + rd_addr) mod DEPTH]`.
  - When `rd_release` is high, go to IDLE.
  - When `arm` is high, the block re-arms directly: same action as `arm` in IDLE. `arm` wins over a simultaneous `rd_release`.
- **Arithmetic**
  - All pointer math is unsigned, `DEPTH_LOG2` bits, wrapping naturally.
  - `pre_q` ≤ `DEPTH-1`, so the post count is always ≥ 1.
  - The window is always exactly `DEPTH` samples: `pre_q` before the trigger sample, plus the trigger sample and `DEPTH-pre_q-1` after it.
- **Boundaries**
  - `arm` while `busy` is ignored.
  - Asserting `rst` mid-capture aborts immediately to reset values; the window is lost.
  - `trigger` stuck high on entry to ARMED cannot occur, because `trig_rst` was 1 during PRE_FILL.

## Timing
- `arm` sampled at edge N → `state` = PRE_FILL after edge N. `busy` and `trig_rst` are registered alongside `state`.
- Fill complete at edge M → ARMED after edge M, `trig_rst` = 0 after edge M. The trigger block therefore runs from edge M+1.
- The trigger event is seen combinationally in ARMED; `state` = POST after that edge.
- Last post write at edge K → `done` = 1 and `trig_rst` = 1 after edge K.
- `rd_addr` presented before edge R → `rd_data` is valid after edge R. Outside DONE, `rd_data` = 0.
- `rd_release` at edge S → `done` = 0 and IDLE after edge S.

## Test plan
1. DEPTH_LOG2=4, `pre_samples`=4, `data_valid`=1, `data` = counter 0,1,2,…, arm, `force` pulsed on the cycle `data`=20 → `done` asserts after 12 post writes; `rd_addr` 0..15 returns 16..31.
2. Same setup with `pre_samples`=0, trigger when `data`=5 → window returns 5..20; `trig_rst` is low for exactly the ARMED and POST cycles.
3. `pre_samples`=15, trigger immediately on entering ARMED → exactly 1 post write; window returns 0..15.
4. `data_valid` toggling 1/0, trigger raised in a cycle with `data_valid`=0 → the trigger sample is the next valid sample; it appears at `rd_addr`=`pre_samples`.
5. `rst` asserted in POST → `state`=0, `trig_rst`=1, `done`=0 asynchronously. A following arm captures a correct new window.
6. In DONE, assert `arm` and `rd_release` together → `state`=PRE_FILL with the new `pre_samples` latched. `arm` while `busy` → no state change.
